// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, RGB332 field widths and polarity encodings
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 29;

  localparam int R_W   = 3;
  localparam int G_W   = 3;
  localparam int B_W   = 2;
  localparam int RGB_W = R_W + G_W + B_W;

  localparam logic POL_ACTIVE_LOW  = 1'b0;
  localparam logic POL_ACTIVE_HIGH = 1'b1;

  localparam int MAX_PIPE = 7;

  // Raw (active-high) timing flags carried alongside the pixel-source latency.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_bus_t;

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - enabled shift register of configurable width and depth, depth 0 is a wire
module vga_delay_line #(
  parameter int W     = 3,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, en};
    assign dout        = din;
  end else begin : g_shift
    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    always_comb begin
      for (int i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
      if (en) begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
      end
    end

    // Reset fills every stage with zeros, i.e. inactive sync and blank.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster engine: coordinates out, latency-aligned sync/RGB back
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = POL_ACTIVE_LOW,
  parameter logic VS_POL   = POL_ACTIVE_LOW,
  parameter int   PIPE     = 0,
  parameter int   CW       = 10
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             pix_en,
  output logic [CW-1:0]    x,
  output logic [CW-1:0]    y,
  output logic             req_de,
  output logic             line_start,
  output logic             frame_start,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [R_W-1:0]   red,
  output logic [G_W-1:0]   green,
  output logic [B_W-1:0]   blue,
  output logic [7:0]       frame_cnt
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  if (PIPE < 0 || PIPE > MAX_PIPE) begin : g_bad_pipe
    $fatal(1, "vga_timing_gen: PIPE must be in 0..7");
  end
  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_total
    $fatal(1, "vga_timing_gen: line or frame total exceeds 2^CW");
  end

  logic [CW-1:0]    hc_q, hc_d;
  logic [CW-1:0]    vc_q, vc_d;
  logic [7:0]       fc_q, fc_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    fc_d = fc_q;
    if (pix_en) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        if (vc_q == V_LAST) begin
          vc_d = '0;
          fc_d = fc_q + 8'd1;
        end else begin
          vc_d = vc_q + CW'(1);
        end
      end else begin
        hc_d = hc_q + CW'(1);
      end
    end
  end

  // Widen to 32 bits so a sync end equal to 2^CW still compares correctly.
  logic [31:0] hc_w, vc_w;
  logic        hs_raw, vs_raw, de_raw;
  assign hc_w   = 32'(hc_q);
  assign vc_w   = 32'(vc_q);
  assign hs_raw = (hc_w >= 32'(HS_START)) && (hc_w < 32'(HS_END));
  assign vs_raw = (vc_w >= 32'(VS_START)) && (vc_w < 32'(VS_END));
  assign de_raw = (hc_w < 32'(H_ACTIVE)) && (vc_w < 32'(V_ACTIVE));

  sync_bus_t raw_s, del_s;
  assign raw_s = {hs_raw, vs_raw, de_raw};

  vga_delay_line #(
    .W     ($bits(sync_bus_t)),
    .DEPTH (PIPE)
  ) u_align (
    .clk   (clk),
    .rst_n (clr_n),
    .en    (pix_en),
    .din   (raw_s),
    .dout  (del_s)
  );

  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    rgb_d   = rgb_q;
    if (pix_en) begin
      hsync_d = del_s.hs ? HS_POL : ~HS_POL;
      vsync_d = del_s.vs ? VS_POL : ~VS_POL;
      de_d    = del_s.de;
      rgb_d   = del_s.de ? rgb_in : '0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hc_q    <= '0;
      vc_q    <= '0;
      fc_q    <= '0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      fc_q    <= fc_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
    end
  end

  assign x           = hc_q;
  assign y           = vc_q;
  assign req_de      = de_raw;
  assign line_start  = (hc_q == '0);
  assign frame_start = (hc_q == '0) && (vc_q == '0);
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign red         = rgb_q[RGB_W-1 -: R_W];
  assign green       = rgb_q[B_W +: G_W];
  assign blue        = rgb_q[B_W-1:0];
  assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench: default timing plus small rasters for frame, latency, rate and polarity
module tb_vga_timing_gen;

  logic clk    = 1'b0;
  logic clr_n  = 1'b0;
  logic pix_en = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  always #5 clk = ~clk;

  // Small raster: H 8+2+3+2=15, V 4+1+2+1=8, frame = 120 ticks.
  logic [9:0] d_x, d_y;
  logic       d_req_de, d_line_start, d_frame_start, d_hsync, d_vsync, d_de;
  logic [2:0] d_red, d_green;
  logic [1:0] d_blue;
  logic [7:0] d_frame_cnt;
  logic [7:0] d_rgb_in = 8'hFF;

  logic [3:0] s_x, s_y, p_x, p_y, h_x, h_y;
  logic       s_req_de, s_line_start, s_frame_start, s_hsync, s_vsync, s_de;
  logic       p_req_de, p_line_start, p_frame_start, p_hsync, p_vsync, p_de;
  logic       h_req_de, h_line_start, h_frame_start, h_hsync, h_vsync, h_de;
  logic [2:0] s_red, s_green, p_red, p_green, h_red, h_green;
  logic [1:0] s_blue, p_blue, h_blue;
  logic [7:0] s_frame_cnt, p_frame_cnt, h_frame_cnt;
  logic [7:0] s_rgb_in = 8'hA5;
  logic [7:0] h_rgb_in = 8'h3C;
  logic [7:0] p_rgb_in;
  logic [3:0] m1, m2, m3;

  // Pixel source model with a 3-tick latency for the PIPE=3 instance.
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m1 <= 4'd0; m2 <= 4'd0; m3 <= 4'd0;
    end else if (pix_en) begin
      m1 <= p_x; m2 <= m1; m3 <= m2;
    end
  end
  assign p_rgb_in = {4'h5, m3};

  vga_timing_gen u_def (
    .clk(clk), .clr_n(clr_n), .pix_en(pix_en), .x(d_x), .y(d_y), .req_de(d_req_de),
    .line_start(d_line_start), .frame_start(d_frame_start), .rgb_in(d_rgb_in),
    .hsync(d_hsync), .vsync(d_vsync), .de(d_de), .red(d_red), .green(d_green),
    .blue(d_blue), .frame_cnt(d_frame_cnt));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                   .V_SYNC(2), .V_BP(1), .PIPE(0), .CW(4)) u_sm (
    .clk(clk), .clr_n(clr_n), .pix_en(pix_en), .x(s_x), .y(s_y), .req_de(s_req_de),
    .line_start(s_line_start), .frame_start(s_frame_start), .rgb_in(s_rgb_in),
    .hsync(s_hsync), .vsync(s_vsync), .de(s_de), .red(s_red), .green(s_green),
    .blue(s_blue), .frame_cnt(s_frame_cnt));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                   .V_SYNC(2), .V_BP(1), .PIPE(3), .CW(4)) u_p3 (
    .clk(clk), .clr_n(clr_n), .pix_en(pix_en), .x(p_x), .y(p_y), .req_de(p_req_de),
    .line_start(p_line_start), .frame_start(p_frame_start), .rgb_in(p_rgb_in),
    .hsync(p_hsync), .vsync(p_vsync), .de(p_de), .red(p_red), .green(p_green),
    .blue(p_blue), .frame_cnt(p_frame_cnt));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                   .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .PIPE(0), .CW(4)) u_hp (
    .clk(clk), .clr_n(clr_n), .pix_en(pix_en), .x(h_x), .y(h_y), .req_de(h_req_de),
    .line_start(h_line_start), .frame_start(h_frame_start), .rgb_in(h_rgb_in),
    .hsync(h_hsync), .vsync(h_vsync), .de(h_de), .red(h_red), .green(h_green),
    .blue(h_blue), .frame_cnt(h_frame_cnt));

  task automatic apply_reset();
    clr_n  = 1'b0;
    pix_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr_n  = 1'b1;
  endtask

  task automatic test_reset();
    clr_n  = 1'b0;
    pix_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({d_hsync, d_vsync, d_de} !== 3'b110) begin bad++;
      $display("FAIL reset_def_sync got=%b exp=110", {d_hsync, d_vsync, d_de}); end
    total++; if ({d_red, d_green, d_blue} !== 8'h00) begin bad++;
      $display("FAIL reset_def_rgb got=%h exp=00", {d_red, d_green, d_blue}); end
    total++; if (d_frame_cnt !== 8'd0) begin bad++;
      $display("FAIL reset_frame_cnt got=%0d exp=0", d_frame_cnt); end
    total++; if ({h_hsync, h_vsync, h_de} !== 3'b000) begin bad++;
      $display("FAIL reset_pol_sync got=%b exp=000", {h_hsync, h_vsync, h_de}); end
    total++; if ({p_hsync, p_vsync, p_de, p_red, p_green, p_blue} !== 11'b110_0000_0000) begin bad++;
      $display("FAIL reset_pipe_out got=%b exp=11000000000", {p_hsync, p_vsync, p_de, p_red, p_green, p_blue}); end
    clr_n = 1'b1;
    #1;
    total++; if ({d_x, d_y} !== 20'd0) begin bad++;
      $display("FAIL release_xy got=%0d,%0d exp=0,0", d_x, d_y); end
    total++; if ({d_req_de, d_line_start, d_frame_start} !== 3'b111) begin bad++;
      $display("FAIL release_flags got=%b exp=111", {d_req_de, d_line_start, d_frame_start}); end
    total++; if ({d_hsync, d_vsync, d_de} !== 3'b110) begin bad++;
      $display("FAIL release_sync got=%b exp=110", {d_hsync, d_vsync, d_de}); end
  endtask

  task automatic test_line();
    int lo_cnt, first_lo, de_cnt, rgb_err;
    lo_cnt = 0; first_lo = -1; de_cnt = 0; rgb_err = 0;
    for (int j = 1; j <= 800; j++) begin
      @(posedge clk); #1;
      if (!d_hsync) begin
        lo_cnt++;
        if (first_lo < 0) first_lo = j;
      end
      if (d_de) de_cnt++;
      if ({d_red, d_green, d_blue} !== (d_de ? 8'hFF : 8'h00)) rgb_err++;
    end
    total++; if (lo_cnt != 96) begin bad++; $display("FAIL line_hs_width got=%0d exp=96", lo_cnt); end
    total++; if (first_lo != 657) begin bad++; $display("FAIL line_hs_first got=%0d exp=657", first_lo); end
    total++; if (de_cnt != 640) begin bad++; $display("FAIL line_de_count got=%0d exp=640", de_cnt); end
    total++; if (rgb_err != 0) begin bad++; $display("FAIL line_blank_rgb got=%0d exp=0", rgb_err); end
    total++; if ({d_x, d_y} !== {10'd0, 10'd1}) begin bad++;
      $display("FAIL line_wrap_xy got=%0d,%0d exp=0,1", d_x, d_y); end
    total++; if ({d_line_start, d_frame_start, d_vsync} !== 3'b101) begin bad++;
      $display("FAIL line_wrap_flags got=%b exp=101", {d_line_start, d_frame_start, d_vsync}); end
  endtask

  task automatic test_frame();
    int fs_err, vs_lo, hs_lo, fc1, fc255;
    fs_err = 0; vs_lo = 0; hs_lo = 0; fc1 = -1; fc255 = -1;
    apply_reset();
    for (int j = 1; j <= 256 * 120; j++) begin
      @(posedge clk); #1;
      if (s_frame_start !== ((j % 120) == 0)) fs_err++;
      if (j <= 120) begin
        if (!s_vsync) vs_lo++;
        if (!s_hsync) hs_lo++;
      end
      if (j == 120) fc1 = int'(s_frame_cnt);
      if (j == 255 * 120) fc255 = int'(s_frame_cnt);
    end
    total++; if (fs_err != 0) begin bad++; $display("FAIL frame_start_period got=%0d exp=0", fs_err); end
    total++; if (vs_lo != 30) begin bad++; $display("FAIL frame_vs_width got=%0d exp=30", vs_lo); end
    total++; if (hs_lo != 24) begin bad++; $display("FAIL frame_hs_total got=%0d exp=24", hs_lo); end
    total++; if (fc1 != 1) begin bad++; $display("FAIL frame_cnt_first got=%0d exp=1", fc1); end
    total++; if (fc255 != 255) begin bad++; $display("FAIL frame_cnt_255 got=%0d exp=255", fc255); end
    total++; if (s_frame_cnt !== 8'd0) begin bad++; $display("FAIL frame_cnt_wrap got=%0d exp=0", s_frame_cnt); end
  endtask

  task automatic test_pipe3();
    int err, xerr, de_cnt, first_err, c, k, hc, vc;
    logic exp_hs, exp_vs, exp_de, de3, de4;
    logic [7:0] exp_rgb, rgb4;
    err = 0; xerr = 0; de_cnt = 0; first_err = -1;
    de3 = 1'bx; de4 = 1'bx; rgb4 = 8'hxx;
    apply_reset();
    for (int j = 1; j <= 240; j++) begin
      @(posedge clk); #1;
      c = j % 120;
      if ({p_x, p_y} !== {4'(c % 15), 4'(c / 15)}) xerr++;
      if (j < 4) begin
        exp_hs = 1'b1; exp_vs = 1'b1; exp_de = 1'b0; exp_rgb = 8'h00;
      end else begin
        k = (j - 4) % 120; hc = k % 15; vc = k / 15;
        exp_de  = (hc < 8) && (vc < 4);
        exp_hs  = !((hc >= 10) && (hc <= 12));
        exp_vs  = !((vc >= 5) && (vc <= 6));
        exp_rgb = exp_de ? {4'h5, 4'(hc)} : 8'h00;
      end
      if ({p_hsync, p_vsync, p_de} !== {exp_hs, exp_vs, exp_de} ||
          {p_red, p_green, p_blue} !== exp_rgb) begin
        err++;
        if (first_err < 0) first_err = j;
      end
      if (p_de) de_cnt++;
      if (j == 3) de3 = p_de;
      if (j == 4) begin de4 = p_de; rgb4 = {p_red, p_green, p_blue}; end
    end
    total++; if (xerr != 0) begin bad++; $display("FAIL pipe_coord got=%0d exp=0", xerr); end
    total++; if (err != 0) begin bad++;
      $display("FAIL pipe_align got=%0d errors (first at tick %0d) exp=0", err, first_err); end
    total++; if (de_cnt != 64) begin bad++; $display("FAIL pipe_de_count got=%0d exp=64", de_cnt); end
    total++; if ({de3, de4} !== 2'b01) begin bad++; $display("FAIL pipe_latency got=%b exp=01", {de3, de4}); end
    total++; if (rgb4 !== 8'h50) begin bad++; $display("FAIL pipe_first_rgb got=%h exp=50", rgb4); end
  endtask

  task automatic test_half_rate();
    int lo, de_clks, hold_err;
    logic [18:0] prev, snap;
    lo = 0; de_clks = 0; hold_err = 0;
    apply_reset();
    prev = {s_x, s_y, s_hsync, s_vsync, s_de, s_red, s_green, s_blue};
    for (int k = 1; k <= 60; k++) begin
      pix_en = ((k % 2) == 1);
      @(posedge clk); #1;
      snap = {s_x, s_y, s_hsync, s_vsync, s_de, s_red, s_green, s_blue};
      if (!pix_en && (snap !== prev)) hold_err++;
      if (!s_hsync) lo++;
      if (s_de) de_clks++;
      prev = snap;
    end
    pix_en = 1'b1;
    total++; if (hold_err != 0) begin bad++; $display("FAIL half_hold got=%0d exp=0", hold_err); end
    total++; if (lo != 12) begin bad++; $display("FAIL half_hs_clks got=%0d exp=12", lo); end
    total++; if (de_clks != 32) begin bad++; $display("FAIL half_de_clks got=%0d exp=32", de_clks); end
    total++; if ({s_x, s_y} !== {4'd0, 4'd2}) begin bad++;
      $display("FAIL half_xy got=%0d,%0d exp=0,2", s_x, s_y); end
  endtask

  task automatic test_pol_reset();
    int n, hs_err;
    logic [3:0] x1, x10;
    logic       de1;
    n = 0; hs_err = 0; x1 = 4'hx; x10 = 4'hx; de1 = 1'bx;
    apply_reset();
    while (!(h_x == 4'd11 && h_y == 4'd5) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    total++; if (n != 86) begin bad++; $display("FAIL pol_reach got=%0d exp=86", n); end
    total++; if ({h_hsync, h_vsync} !== 2'b11) begin bad++;
      $display("FAIL pol_active got=%b exp=11", {h_hsync, h_vsync}); end
    #2;
    clr_n = 1'b0;
    #1;
    total++; if ({h_hsync, h_vsync, h_de} !== 3'b000) begin bad++;
      $display("FAIL pol_async_drop got=%b exp=000", {h_hsync, h_vsync, h_de}); end
    total++; if ({h_x, h_y, h_frame_start} !== 9'b0000_0000_1) begin bad++;
      $display("FAIL pol_async_coord got=%0d,%0d fs=%b exp=0,0 fs=1", h_x, h_y, h_frame_start); end
    @(posedge clk); #1;
    clr_n = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk); #1;
      if (h_hsync !== 1'b0 || h_vsync !== 1'b0) hs_err++;
      if (j == 1) begin x1 = h_x; de1 = h_de; end
      if (j == 10) x10 = h_x;
    end
    total++; if (hs_err != 0) begin bad++; $display("FAIL pol_no_extend got=%0d exp=0", hs_err); end
    total++; if ({x1, de1} !== {4'd1, 1'b1}) begin bad++;
      $display("FAIL pol_restart got=x%0d de%b exp=x1 de1", x1, de1); end
    total++; if (x10 !== 4'd10) begin bad++; $display("FAIL pol_restart_run got=%0d exp=10", x10); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_pipe3();
    test_half_rate();
    test_pol_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator for the display path. It replaces the fixed 640x480 colour-bar block with a configurable raster engine. It issues pixel coordinates to an upstream pixel source (e.g. cube renderer) and accepts RGB332 data back after a fixed pipeline latency. It then emits hsync/vsync/RGB aligned to that data, with configurable sync polarity and a pixel-clock enable.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 29, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
PIPE, 0, pixel-source latency in pix_en ticks (0..7)
CW, 10, coordinate/counter width; H_TOTAL and V_TOTAL must be <= 2^CW

Ports:
clk  in  1  system clock
clr_n  in  1  asynchronous active-low reset
pix_en  in  1  pixel tick; counters and pipeline advance only on clk edges with pix_en=1
x  out  CW  current horizontal counter hc
y  out  CW  current vertical counter vc
req_de  out  1  coordinate is visible (hc<H_ACTIVE && vc<V_ACTIVE)
line_start  out  1  hc==0
frame_start  out  1  hc==0 && vc==0
rgb_in  in  8  {R[2:0],G[2:0],B[1:0]} for the coordinate issued PIPE ticks earlier
hsync  out  1  horizontal sync, registered
vsync  out  1  vertical sync, registered
de  out  1  delayed data-enable, registered
red  out  3  red output, registered
green  out  3  green output, registered
blue  out  2  blue output, registered
frame_cnt  out  8  completed-frame counter, wraps at 255->0

Behaviour:
- Interface: one clock (clk); reset clr_n is asynchronous and active-low.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 521).
- Line order is active, FP, sync, BP. Frame order is the same.
- Counters: on a pix_en edge, hc increments. At hc==H_TOTAL-1, hc wraps to 0 and vc increments. At vc==V_TOTAL-1 on that same wrap, vc goes to 0 and frame_cnt increments (modulo 256).
- Counters hold while pix_en=0.
- x, y, req_de, line_start and frame_start are functions of the registered counters. They are stable for a whole pixel period.
- Sync decode (at the coordinate stage):
  - hs_raw is asserted when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - vs_raw is asserted when V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (default 490..491), for the full lines.
- Alignment pipeline: {hs_raw, vs_raw, req_de} pass through a PIPE-deep shift register that advances only on pix_en.
- Output register: loads on a pix_en edge from the pipeline tail (or directly from the raw decode when PIPE=0) and from rgb_in.
  - Output timing therefore lags the coordinate by PIPE+1 pix_en edges.
  - rgb_in is sampled on the same edge as the pipeline tail.
- Blanking: when the delayed de=0, red/green/blue load 0 regardless of rgb_in.
- Polarity: hsync = hs_del ? HS_POL : ~HS_POL; vsync likewise with VS_POL.
- Reset (async assert, synchronous-to-clk deassert by system):
  - hc, vc and frame_cnt are 0.
  - The pipeline is filled with inactive/blank.
  - hsync = ~HS_POL, vsync = ~VS_POL, de = 0, RGB = 0.
  - Outputs after release: x=0, y=0, req_de=1, line_start=1, frame_start=1.
- Reset mid-frame: immediate return to the values above. No partial sync pulse may be extended.
- Continuous pix_en=1: one pixel per clk. pix_en toggling every other clk: half rate, with all outputs held between ticks.
- Elaboration: a PIPE outside 0..7, or a total exceeding 2^CW, is a fatal parameter error.

Decomposition:
- Shared package vga_pkg holds the default timing constants (640x480@60), the RGB332 field widths and the polarity encodings.
- One natural sub-module is vga_delay_line: a parametrised-width, parametrised-depth shift register with enable. It is instantiated once for sync/de alignment.

Test Plan:
- Reset with defaults, PIPE=0, pix_en=1 -> hsync=1, vsync=1, de=0, RGB=0. After release, x=0, y=0, frame_start=1.
- Run one line -> hsync low for exactly 96 clks, first low output at the edge after hc=656. de high for 640 clks per visible line.
- Run a full frame -> frame_start recurs every 416800 clks, vsync low for 1600 clks, frame_cnt increments by 1. After 256 frames frame_cnt wraps to 0.
- PIPE=3, rgb_in = x[7:0] via a 3-tick model -> on every de=1 output, {red,green,blue} equals the low byte of the x issued 4 ticks earlier. Blanking lines output 0.
- pix_en = 1 every other clk -> all timings double in clks. Outputs are stable on non-enabled clks.
- HS_POL=1, VS_POL=1, with clr_n pulsed low at vc=490, hc=700 -> hsync/vsync drop to 0 asynchronously, then restart cleanly from hc=vc=0.
